// File: rtl/flash_cmd_sequencer.sv
// Parses W/R command bytes from the UART link, runs one Flash transaction and returns one response byte.
// Build option CMD_CHECKSUM_EN: each command carries a trailing XOR checksum byte.
module flash_cmd_sequencer #(
    parameter int BYTE_TIMEOUT = 2500000,
    parameter int FL_TIMEOUT   = 50000
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       fl_start,
    output logic       fl_rw,
    output logic [7:0] fl_addr,
    output logic [7:0] fl_wdata,
    input  logic       fl_done,
    input  logic [7:0] fl_rdata,
    output logic       busy,
    output logic       ovr
);

    localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int FT_W = $clog2(FL_TIMEOUT + 1);
    localparam logic [BT_W-1:0] BT_MAX = BT_W'(BYTE_TIMEOUT);
    localparam logic [FT_W-1:0] FT_MAX = FT_W'(FL_TIMEOUT);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_UNK  = 8'h3F;
    localparam logic [7:0] RSP_ERR  = 8'h45;
`ifdef CMD_CHECKSUM_EN
    localparam logic [7:0] RSP_CSUM = 8'h43;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_GET_SUM,
        S_FL_ISSUE,
        S_FL_WAIT,
        S_TX_RESP,
        S_TX_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic            is_read_q, is_read_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif
    logic [BT_W-1:0] bt_q, bt_d;
    logic [FT_W-1:0] ft_q, ft_d;
    logic            seen_busy_q, seen_busy_d;
    logic            txw_q, txw_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            fl_start_q, fl_start_d;
    logic            fl_rw_q, fl_rw_d;
    logic [7:0]      fl_addr_q, fl_addr_d;
    logic [7:0]      fl_wdata_q, fl_wdata_d;
    logic            busy_q, busy_d;
    logic            ovr_q, ovr_d;

    logic            go_issue;
    logic            go_resp;
    logic [7:0]      resp_val;

    always_comb begin
        state_d     = state_q;
        is_read_d   = is_read_q;
        addr_d      = addr_q;
        data_d      = data_q;
`ifdef CMD_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        bt_d        = bt_q;
        ft_d        = ft_q;
        seen_busy_d = seen_busy_q;
        txw_d       = txw_q;
        tx_data_d   = tx_data_q;
        fl_start_d  = 1'b0;
        fl_rw_d     = fl_rw_q;
        fl_addr_d   = fl_addr_q;
        fl_wdata_d  = fl_wdata_q;
        ovr_d       = ovr_q;
        go_issue    = 1'b0;
        go_resp     = 1'b0;
        resp_val    = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                        is_read_d = (rx_data == OP_READ);
                        addr_d    = 8'h00;
                        data_d    = 8'h00;
`ifdef CMD_CHECKSUM_EN
                        csum_d    = rx_data;
`endif
                        bt_d      = '0;
                        state_d   = S_GET_ADDR;
                    end else begin
                        go_resp  = 1'b1;
                        resp_val = RSP_UNK;
                    end
                end
            end
            S_GET_ADDR: begin
                if (rx_valid) begin
                    addr_d = rx_data;
                    bt_d   = '0;
`ifdef CMD_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
                    state_d = is_read_q ? S_GET_SUM : S_GET_DATA;
`else
                    if (is_read_q) go_issue = 1'b1;
                    else           state_d  = S_GET_DATA;
`endif
                end else if (bt_q == BT_MAX) begin
                    state_d = S_IDLE;
                end else begin
                    bt_d = bt_q + 1'b1;
                end
            end
            S_GET_DATA: begin
                if (rx_valid) begin
                    data_d = rx_data;
                    bt_d   = '0;
`ifdef CMD_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
                    state_d = S_GET_SUM;
`else
                    go_issue = 1'b1;
`endif
                end else if (bt_q == BT_MAX) begin
                    state_d = S_IDLE;
                end else begin
                    bt_d = bt_q + 1'b1;
                end
            end
`ifdef CMD_CHECKSUM_EN
            S_GET_SUM: begin
                if (rx_valid) begin
                    bt_d = '0;
                    if (rx_data == csum_q) begin
                        go_issue = 1'b1;
                    end else begin
                        go_resp  = 1'b1;
                        resp_val = RSP_CSUM;
                    end
                end else if (bt_q == BT_MAX) begin
                    state_d = S_IDLE;
                end else begin
                    bt_d = bt_q + 1'b1;
                end
            end
`endif
            S_FL_ISSUE: begin
                ft_d    = ft_q + 1'b1;
                state_d = S_FL_WAIT;
            end
            S_FL_WAIT: begin
                // fl_done takes priority over a timeout landing in the same cycle
                if (fl_done) begin
                    go_resp  = 1'b1;
                    resp_val = is_read_q ? fl_rdata : RSP_OK;
                end else if (ft_q == FT_MAX) begin
                    go_resp  = 1'b1;
                    resp_val = RSP_ERR;
                end else begin
                    ft_d = ft_q + 1'b1;
                end
            end
            S_TX_RESP: begin
                if (!tx_busy) begin
                    seen_busy_d = 1'b0;
                    txw_d       = 1'b0;
                    state_d     = S_TX_WAIT;
                end
            end
            S_TX_WAIT: begin
                txw_d = 1'b1;
                if (tx_busy) seen_busy_d = 1'b1;
                // Leave on busy falling, or if the UART never raised busy within 2 cycles
                if (!tx_busy && (seen_busy_q || txw_q)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (go_issue) begin
            state_d    = S_FL_ISSUE;
            fl_start_d = 1'b1;
            fl_rw_d    = is_read_d;
            fl_addr_d  = addr_d;
            fl_wdata_d = data_d;
            ft_d       = '0;
        end
        if (go_resp) begin
            state_d   = S_TX_RESP;
            tx_data_d = resp_val;
        end

        if (rx_valid && (state_q == S_FL_ISSUE || state_q == S_FL_WAIT ||
                         state_q == S_TX_RESP  || state_q == S_TX_WAIT)) begin
            ovr_d = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state_q     <= S_IDLE;
            is_read_q   <= 1'b0;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
`ifdef CMD_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
            bt_q        <= '0;
            ft_q        <= '0;
            seen_busy_q <= 1'b0;
            txw_q       <= 1'b0;
            tx_data_q   <= 8'h00;
            fl_start_q  <= 1'b0;
            fl_rw_q     <= 1'b0;
            fl_addr_q   <= 8'h00;
            fl_wdata_q  <= 8'h00;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_read_q   <= is_read_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
`ifdef CMD_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
            bt_q        <= bt_d;
            ft_q        <= ft_d;
            seen_busy_q <= seen_busy_d;
            txw_q       <= txw_d;
            tx_data_q   <= tx_data_d;
            fl_start_q  <= fl_start_d;
            fl_rw_q     <= fl_rw_d;
            fl_addr_q   <= fl_addr_d;
            fl_wdata_q  <= fl_wdata_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
        end
    end

    // tx_start decodes tx_busy directly so the byte goes out in the first cycle the UART is free
    assign tx_start = (state_q == S_TX_RESP) && !tx_busy;
    assign tx_data  = tx_data_q;
    assign fl_start = fl_start_q;
    assign fl_rw    = fl_rw_q;
    assign fl_addr  = fl_addr_q;
    assign fl_wdata = fl_wdata_q;
    assign busy     = busy_q;
    assign ovr      = ovr_q;

endmodule

// File: doc/flash_cmd_sequencer.md
Name: flash_cmd_sequencer

Overview:
Command scheduler between the UART byte link and the Flash byte controller. It parses opcode/address/data byte streams received over RS-232 and issues one Flash read or write transaction per command. It then returns one response byte over the UART. It sits beside the existing manager logic at top level and owns the Flash request handshake.

Parameters:
BYTE_TIMEOUT, 2500000, max clock cycles between bytes of one command (50 ms at 50 MHz); expiry aborts the command.
FL_TIMEOUT, 50000, max cycles from fl_start to fl_done; expiry gives an error response.

Ports:
CLK_50MHZ  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle pulse; rx_data holds a received UART byte
rx_data  in  8  received byte
tx_busy  in  1  UART transmitter busy; tx_start ignored while high
tx_start  out  1  one-cycle pulse; UART sends tx_data
tx_data  out  8  response byte, stable from tx_start until tx_busy falls
fl_start  out  1  one-cycle pulse starting a Flash transaction
fl_rw  out  1  1=read, 0=write; stable from fl_start until fl_done
fl_addr  out  8  Flash byte address, stable as fl_rw
fl_wdata  out  8  write data, stable as fl_rw
fl_done  in  1  one-cycle pulse; transaction complete
fl_rdata  in  8  read data, valid in the fl_done cycle
busy  out  1  high in every state except IDLE
ovr  out  1  sticky; set when rx_valid arrives in FL_ISSUE..TX_WAIT; cleared only by RST

Behaviour:
- Reset: state=IDLE; tx_start=0, tx_data=0, fl_start=0, fl_rw=0, fl_addr=0, fl_wdata=0, busy=0, ovr=0; timers cleared. RST mid-transaction abandons it immediately with no response. A pending fl_done is ignored.
- Opcodes: 0x57 'W' = opcode, addr, data. 0x52 'R' = opcode, addr. Any other byte in IDLE -> response 0x3F '?'.
- States: IDLE -> GET_ADDR (valid opcode) | TX_RESP ('?'); GET_ADDR -> GET_DATA (W) | FL_ISSUE (R); GET_DATA -> FL_ISSUE; FL_ISSUE -> FL_WAIT; FL_WAIT -> TX_RESP; TX_RESP -> TX_WAIT; TX_WAIT -> IDLE.
- Latency: final command byte rx_valid in cycle N -> fl_start high in cycle N+1 (FL_ISSUE is a single cycle). fl_done in cycle M -> response latched in M; tx_start in M+1 if tx_busy=0, else in the first cycle with tx_busy=0.
- Responses: W success 0x4B 'K'; R success = fl_rdata captured at fl_done; Flash timeout 0x45 'E'.
- TX_WAIT: wait for tx_busy to rise then fall; also exits if tx_busy is still low 2 cycles after tx_start. Then go to IDLE.
- Byte timer: reset on every accepted byte, runs only in GET_ADDR/GET_DATA/GET_SUM. Reaching BYTE_TIMEOUT returns to IDLE silently with no response and no Flash access.
- Flash timer: starts at fl_start. Reaching FL_TIMEOUT without fl_done -> response 'E'. A late fl_done after that is ignored.
- fl_done and a timer expiry in the same cycle: fl_done wins.
- rx_valid in FL_ISSUE, FL_WAIT, TX_RESP or TX_WAIT: byte discarded, ovr set.
- rx_valid and timer expiry in the same cycle: the byte is accepted and the timer restarts.
- Counter widths: $clog2(param+1); no wrap (timers saturate at expiry).

Optional Feature:
Macro CMD_CHECKSUM_EN.
- Defined: a trailing byte is required after the last command byte (state GET_SUM). It must equal the XOR of all preceding command bytes. Match -> FL_ISSUE. Mismatch -> response 0x43 'C' with no Flash access. The fl_start latency of N+1 counts from the checksum byte. Unknown opcodes still reply '?' immediately.
- Undefined: GET_SUM is absent and the command executes after its last byte.

Test Plan:
- Write: bytes 0x57,0x10,0xA5 -> fl_start one cycle after 0xA5 with fl_rw=0, fl_addr=0x10, fl_wdata=0xA5; fl_done -> tx_start next cycle with tx_data=0x4B; busy falls after tx completes.
- Read: 0x52,0x22 with fl_rdata=0x3C at fl_done -> fl_rw=1, fl_addr=0x22; tx_data=0x3C.
- Bad opcode 0x00 -> no fl_start; tx_data=0x3F. Then 0x52,0x01 executes normally.
- Timeouts (BYTE_TIMEOUT=20, FL_TIMEOUT=30): 0x57,0x10 then silence -> IDLE after 20 cycles, no tx_start, no fl_start. Read with fl_done withheld -> tx_data=0x45 at cycle 30; a late fl_done is ignored.
- Backpressure/overrun: tx_busy held high 100 cycles at fl_done -> tx_start waits for tx_busy low. An rx_valid during FL_WAIT sets ovr=1, and ovr stays set until RST.
- RST asserted during FL_WAIT -> all outputs reset next cycle. CMD_CHECKSUM_EN: 0x57,0x10,0xA5,0xE2 -> write executes; checksum 0x00 -> 'C', no fl_start.
